// File: rtl/pmu_bitstream_tx.sv
// Serializer for the PMU configuration port: 64-bit {len, addr, opcode} header, then payload words LSB-first.
// Optional request screening is compiled in with `define PMU_TX_LEN_CHECK_EN.
module pmu_bitstream_tx #(
    parameter int unsigned HEADER_WIDTH = 64,
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            opcode,
    input  logic [27:0]           addr,
    input  logic [31:0]           len,
    input  logic [WORD_WIDTH-1:0] word_i,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  en_o,
    output logic                  data_o,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned WBIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [31:0] HDR_LAST = 32'(HEADER_WIDTH - 1);
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
    localparam logic [WBIT_W-1:0] WBIT_LAST = WBIT_W'(WORD_WIDTH - 1);

    localparam logic [3:0] OP_PC_SC  = 4'b1010;
    localparam logic [3:0] OP_PC_MEM = 4'b0001;
    localparam logic [3:0] OP_KEY    = 4'b0010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HEADER,
        ST_PAYLOAD,
        ST_GAP
    } state_t;

    state_t                  state_q, state_d;
    logic [HEADER_WIDTH-1:0] hdr_q, hdr_d;
    logic [31:0]             len_q, len_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [WBIT_W-1:0]       wbit_q, wbit_d;
    logic [WORD_WIDTH-1:0]   word_sh_q, word_sh_d;
    logic [WORD_WIDTH-1:0]   buf_q, buf_d;
    logic                    buf_full_q, buf_full_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;

    logic push;
    logic load_word;
    logic req_ok;

    // Handshake: a word transfers on any rising edge where word_valid && word_ready.
    // word_ready depends only on buffer occupancy (and rst), never on word_valid.
    assign word_ready = !buf_full_q && !rst;
    assign push       = word_valid && word_ready;

`ifdef PMU_TX_LEN_CHECK_EN
    logic op_known;
    logic len_aligned;
    logic key_len_ok;

    always_comb begin
        op_known    = (opcode == OP_PC_SC) || (opcode == OP_PC_MEM) || (opcode == OP_KEY);
        len_aligned = (len % 32'(WORD_WIDTH)) == 32'd0;
        key_len_ok  = (opcode != OP_KEY) || (len == 32'd128);
        req_ok      = op_known && len_aligned && key_len_ok;
    end
`else
    assign req_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        wbit_d    = wbit_q;
        word_sh_d = word_sh_q;
        err_d     = err_q;
        done_d    = 1'b0;
        load_word = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (req_ok) begin
                        hdr_d   = {len, addr, opcode};
                        len_d   = len;
                        cnt_d   = 32'd0;
                        err_d   = 1'b0;
                        state_d = ST_SYNC;
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end

            ST_SYNC: begin
                cnt_d   = 32'd0;
                state_d = ST_HEADER;
            end

            ST_HEADER: begin
                hdr_d = hdr_q >> 1;
                if (cnt_q == HDR_LAST) begin
                    cnt_d  = 32'd0;
                    wbit_d = '0;
                    if (len_q != 32'd0) begin
                        load_word = 1'b1;
                        state_d   = ST_PAYLOAD;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            ST_PAYLOAD: begin
                word_sh_d = word_sh_q >> 1;
                // The final bit never triggers a load, so a partial last word consumes nothing extra.
                if (cnt_q == len_q - 32'd1) begin
                    cnt_d   = 32'd0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if (wbit_q == WBIT_LAST) begin
                        wbit_d    = '0;
                        load_word = 1'b1;
                    end else begin
                        wbit_d = wbit_q + 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 32'd0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An empty buffer at a word boundary sends a zero word; the frame keeps its length.
        if (load_word) begin
            if (buf_full_q) begin
                word_sh_d = buf_q;
            end else begin
                word_sh_d = '0;
                err_d     = 1'b1;
            end
        end
    end

    always_comb begin
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        if (load_word && buf_full_q) begin
            buf_full_d = 1'b0;
        end
        if (push) begin
            buf_d      = word_i;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hdr_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            wbit_q     <= '0;
            word_sh_q  <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            wbit_q     <= wbit_d;
            word_sh_q  <= word_sh_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        en_o   = (state_q == ST_SYNC);
        busy   = (state_q != ST_IDLE);
        done   = done_q;
        err    = err_q;
        data_o = 1'b0;
        if (state_q == ST_HEADER) begin
            data_o = hdr_q[0];
        end else if (state_q == ST_PAYLOAD) begin
            data_o = word_sh_q[0];
        end
    end

endmodule
